ft245_fifo_device_model: RTL

// Synthesizable device-side (chip-side) model of the FT60x 245 synchronous FIFO bus: the

---
 rtl/ft245_fifo_device_model_if.sv | 29 ++
 rtl/ft245_fifo_device_model.sv | 124 ++++++++++++
 2 files changed

// File: rtl/ft245_fifo_device_model_if.sv
// FT245 synchronous FIFO pin bundle between the host-side master and the device model.
// DATA/BE are resolved here from the two drive requests so that each side owns only plain variables.
interface ft245_fifo_device_model_if;
   logic        wr_n;
   logic        rd_n;
   logic        oe_n;
   logic        txe_n;
   logic        rxf_n;
   logic [35:0] dev_q;
   logic        dev_oe;
   logic [35:0] host_q;
   logic        host_oe;
   wire  [31:0] data;
   wire  [3:0]  be;

   // Device drive takes precedence; with neither side enabled the bus floats.
   assign data = dev_oe ? dev_q[31:0]  : (host_oe ? host_q[31:0]  : 'z);
   assign be   = dev_oe ? dev_q[35:32] : (host_oe ? host_q[35:32] : 'z);

   modport master (
      output wr_n, rd_n, oe_n, host_q, host_oe,
      input  txe_n, rxf_n, data, be
   );

   modport slave (
      input  wr_n, rd_n, oe_n, data, be,
      output txe_n, rxf_n, dev_q, dev_oe
   );
endinterface

// File: rtl/ft245_fifo_device_model.sv
// Chip-side responder for the FT245 synchronous FIFO bus: master writes land in a loopback
// FIFO and are returned, in order and with their byte enables, on master reads.
//
// state | meaning
// IDLE  | bus parked, either direction may start
// WRITE | master write burst in progress, reads blocked
// TURN  | write burst ended, waiting out the turnaround gap before offering reads
// READ  | master owns OE_N, model drives DATA/BE, writes blocked
module ft245_fifo_device_model #(
   parameter int DEPTH    = 512,
   parameter int TURN_GAP = 2
) (
   input  logic                     clk_ftdi,
   input  logic                     hrst_n,
   ft245_fifo_device_model_if.slave bus,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     err_ovf,
   output logic                     err_udf,
   output logic                     err_bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WRITE,
      ST_TURN,
      ST_READ
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [3:0]    gap_cnt;
   logic [3:0]    gap_cnt_next;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [LW-1:0] level_next;
   logic          wr_acc;
   logic          rd_acc;
   logic [35:0]   mem [DEPTH];

   // Flags are registered from next-state values, so they already block an illegal
   // write or read; wr_n in rd_acc keeps the two directions exclusive out of IDLE.
   always_comb begin
      wr_acc     = 1'b0;
      rd_acc     = 1'b0;
      wr_acc     = !bus.wr_n && !bus.txe_n;
      rd_acc     = !bus.rd_n && !bus.oe_n && !bus.rxf_n && bus.wr_n;
      level_next = level + LW'(wr_acc) - LW'(rd_acc);
   end

   always_comb begin
      state_next   = state;
      gap_cnt_next = gap_cnt;
      case (state)
         ST_IDLE: begin
            if (!bus.wr_n)
               state_next = ST_WRITE;
            else if (!bus.oe_n && (level != '0))
               state_next = ST_READ;
         end
         ST_WRITE: begin
            if (bus.wr_n) begin
               state_next   = ST_TURN;
               gap_cnt_next = 4'(TURN_GAP - 1);
            end
         end
         ST_TURN: begin
            if (!bus.wr_n)
               state_next = ST_WRITE;
            else if (gap_cnt == '0)
               state_next = ST_IDLE;
            else
               gap_cnt_next = gap_cnt - 4'd1;
         end
         ST_READ: begin
            if (bus.oe_n)
               state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_ftdi or negedge hrst_n) begin
      if (!hrst_n) begin
         state     <= ST_IDLE;
         gap_cnt   <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         bus.txe_n <= 1'b1;
         bus.rxf_n <= 1'b1;
         err_ovf   <= 1'b0;
         err_udf   <= 1'b0;
         err_bus   <= 1'b0;
      end else begin
         state     <= state_next;
         gap_cnt   <= gap_cnt_next;
         level     <= level_next;
         if (wr_acc)
            wr_ptr <= wr_ptr + AW'(1);
         if (rd_acc)
            rd_ptr <= rd_ptr + AW'(1);
         bus.txe_n <= (level_next == LW'(DEPTH)) || (state_next == ST_READ);
         bus.rxf_n <= (level_next == '0) || (state_next == ST_WRITE) || (state_next == ST_TURN);
         err_ovf   <= err_ovf | (!bus.wr_n && bus.txe_n);
         err_udf   <= err_udf | (!bus.rd_n && bus.rxf_n);
         err_bus   <= err_bus | (!bus.wr_n && !bus.oe_n);
      end
   end

   // Storage carries no reset: discarding contents is done by clearing the pointers.
   always_ff @(posedge clk_ftdi) begin
      if (wr_acc)
         mem[wr_ptr] <= {bus.be, bus.data};
   end

   // Show-ahead head word; the drive enable includes hrst_n so reset frees the bus at once.
   assign bus.dev_q  = mem[rd_ptr];
   assign bus.dev_oe = hrst_n && !bus.oe_n &&
                       ((state == ST_READ) || ((state != ST_WRITE) && bus.wr_n));

endmodule
